// File: rtl/gpr_pkg.sv
// Shared sizing for the GPR file and its in-flight write scoreboard.
// Defaults: 32 x 32-bit registers, x0 hardwired zero, 2-bit pending counters.
package gpr_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int PEND_W = 2;

  typedef logic [PEND_W-1:0] pend_t;

  localparam pend_t PEND_MAX = '1;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register outstanding-write counters. Lookups see this cycle's writeback (0-cycle).
// Never stalls anything itself; the caller must withhold inc when rd_eff is saturated.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREG   = gpr_pkg::NREG,
  parameter int PEND_W = gpr_pkg::PEND_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              inc_vld,
  input  logic [REG_AW-1:0] inc_idx,
  input  logic              dec_vld,
  input  logic [REG_AW-1:0] dec_idx,
  input  logic [REG_AW-1:0] rs1_idx,
  input  logic [REG_AW-1:0] rs2_idx,
  input  logic [REG_AW-1:0] rd_idx,
  output logic [PEND_W-1:0] rs1_eff,
  output logic [PEND_W-1:0] rs2_eff,
  output logic [PEND_W-1:0] rd_eff,
  output logic              idle
);

  logic [PEND_W-1:0] pend     [NREG];
  logic [PEND_W-1:0] pend_eff [NREG];
  logic [PEND_W-1:0] pend_nxt [NREG];

  // A writeback retiring against a zero count belongs to a flushed producer; it saturates.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pend_eff[i] = pend[i];
      if (dec_vld && (dec_idx == REG_AW'(i)) && (pend[i] != '0)) begin
        pend_eff[i] = pend[i] - 1'b1;
      end
      pend_nxt[i] = pend_eff[i];
      if (inc_vld && (inc_idx == REG_AW'(i)) && (i != 0) && (pend_eff[i] != '1)) begin
        pend_nxt[i] = pend_eff[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= pend_nxt[i];
      end
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (pend[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  assign rs1_eff = pend_eff[rs1_idx];
  assign rs2_eff = pend_eff[rs2_idx];
  assign rd_eff  = pend_eff[rd_idx];

endmodule

// File: rtl/gpr_wb_regfile.sv
// GPR file with two bypassed combinational read ports and issue interlock on pending writes.
// Writeback is always accepted outside reset; issue stalls on busy sources, saturated rd or flush.
module gpr_wb_regfile
  import gpr_pkg::*;
#(
  parameter int XLEN   = gpr_pkg::XLEN,
  parameter int NREG   = gpr_pkg::NREG,
  parameter int PEND_W = gpr_pkg::PEND_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_R_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_rd_value,
  output logic              wb_ready,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_R_wen,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              idle
);

  logic [XLEN-1:0]   regs [NREG];
  logic              wb_fire;
  logic              id_fire;
  logic              inc_vld;
  logic [PEND_W-1:0] rs1_eff;
  logic [PEND_W-1:0] rs2_eff;
  logic [PEND_W-1:0] rd_eff;
  logic              busy1;
  logic              busy2;
  logic              dfull;

  assign wb_fire  = wb_valid && wb_R_wen && (wb_rd != '0);
  assign wb_ready = !reset;

  assign busy1    = (id_rs1 != '0) && (rs1_eff != '0);
  assign busy2    = (id_rs2 != '0) && (rs2_eff != '0);
  assign dfull    = id_R_wen && (id_rd != '0) && (rd_eff == '1);
  assign id_ready = !reset && !flush && !busy1 && !busy2 && !dfull;
  assign id_fire  = id_valid && id_ready;
  assign inc_vld  = id_fire && id_R_wen && (id_rd != '0);

  gpr_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .inc_vld (inc_vld),
    .inc_idx (id_rd),
    .dec_vld (wb_fire),
    .dec_idx (wb_rd),
    .rs1_idx (id_rs1),
    .rs2_idx (id_rs2),
    .rd_idx  (id_rd),
    .rs1_eff (rs1_eff),
    .rs2_eff (rs2_eff),
    .rd_eff  (rd_eff),
    .idle    (idle)
  );

  // Flushed writebacks still land: the producing instruction was older than the kill.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_fire) begin
      regs[wb_rd] <= wb_rd_value;
    end
  end

  always_comb begin
    rs1_data = regs[id_rs1];
    if (wb_fire && (wb_rd == id_rs1)) begin
      rs1_data = wb_rd_value;
    end
    if (id_rs1 == '0) begin
      rs1_data = '0;
    end
  end

  always_comb begin
    rs2_data = regs[id_rs2];
    if (wb_fire && (wb_rd == id_rs2)) begin
      rs2_data = wb_rd_value;
    end
    if (id_rs2 == '0) begin
      rs2_data = '0;
    end
  end

endmodule

// File: tb/tb_gpr_wb_regfile.sv
// Directed scenarios for gpr_wb_regfile; expected values queued at drive time, popped at sample time.
module tb_gpr_wb_regfile;
  import gpr_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, wb_R_wen, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rd_value;
  logic        id_valid, id_ready, id_R_wen;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] rs1_data, rs2_data;
  logic        flush, idle;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clock = ~clock;

  gpr_wb_regfile dut (
    .clock       (clock),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_R_wen    (wb_R_wen),
    .wb_rd       (wb_rd),
    .wb_rd_value (wb_rd_value),
    .wb_ready    (wb_ready),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_R_wen    (id_R_wen),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .idle        (idle)
  );

  // Start a cycle: inputs change on the falling edge, outputs sampled 4 ns later.
  task automatic new_cycle();
    @(negedge clock);
    reset = 1'b0; flush = 1'b0;
    wb_valid = 1'b0; wb_R_wen = 1'b0; wb_rd = '0; wb_rd_value = '0;
    id_valid = 1'b0; id_R_wen = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
  endtask

  task automatic drive_wb(input logic [4:0] rd, input logic [31:0] v);
    wb_valid = 1'b1; wb_R_wen = 1'b1; wb_rd = rd; wb_rd_value = v;
  endtask

  task automatic drive_id(input logic wen, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1'b1; id_R_wen = wen; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic test_reset();
    new_cycle(); reset = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL reset_id_ready: got %0b want %0b", id_ready, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, wb_ready} !== exp) begin failures++; $display("FAIL reset_wb_ready: got %0b want %0b", wb_ready, exp[0]); end
    new_cycle(); reset = 1'b1;
    new_cycle(); id_rs1 = 5'd1; id_rs2 = 5'd2;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #4;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL reset_rs1: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin failures++; $display("FAIL reset_rs2: got %h want %h", rs2_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL reset_idle: got %0b want %0b", idle, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL post_reset_id_ready: got %0b want %0b", id_ready, exp[0]); end
  endtask

  task automatic test_write_bypass();
    new_cycle(); drive_wb(5'd5, 32'hDEADBEEF); id_rs1 = 5'd5; id_rs2 = 5'd6;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd0);
    #4;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL wb_bypass_rs1: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin failures++; $display("FAIL wb_bypass_other: got %h want %h", rs2_data, exp); end
    new_cycle(); id_rs1 = 5'd6; id_rs2 = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    #4;
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin failures++; $display("FAIL wb_committed: got %h want %h", rs2_data, exp); end
  endtask

  task automatic test_x0();
    new_cycle(); drive_wb(5'd0, 32'h1234); drive_id(1'b1, 5'd0, 5'd0, 5'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    #4;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL x0_bypass_rs1: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin failures++; $display("FAIL x0_bypass_rs2: got %h want %h", rs2_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL x0_issue_ready: got %0b want %0b", id_ready, exp[0]); end
    new_cycle();
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL x0_idle: got %0b want %0b", idle, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL x0_read: got %h want %h", rs1_data, exp); end
  endtask

  task automatic test_raw_stall();
    new_cycle(); drive_id(1'b1, 5'd7, 5'd0, 5'd0);
    exp_q.push_back(32'd1);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL raw_producer_ready: got %0b want %0b", id_ready, exp[0]); end
    for (int c = 0; c < 2; c++) begin
      new_cycle(); drive_id(1'b0, 5'd0, 5'd0, 5'd7);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #4;
      exp = exp_q.pop_front(); checks++;
      if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL raw_stall_c%0d: got %0b want %0b", c, id_ready, exp[0]); end
      exp = exp_q.pop_front(); checks++;
      if ({31'd0, idle} !== exp) begin failures++; $display("FAIL raw_idle_c%0d: got %0b want %0b", c, idle, exp[0]); end
    end
    new_cycle(); drive_id(1'b0, 5'd0, 5'd0, 5'd7); drive_wb(5'd7, 32'h55);
    exp_q.push_back(32'd1); exp_q.push_back(32'h55);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL raw_release: got %0b want %0b", id_ready, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin failures++; $display("FAIL raw_bypass: got %h want %h", rs2_data, exp); end
    new_cycle();
    exp_q.push_back(32'd1);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL raw_idle_after: got %0b want %0b", idle, exp[0]); end
  endtask

  task automatic test_dest_saturation();
    for (int c = 0; c < 3; c++) begin
      new_cycle(); drive_id(1'b1, 5'd9, 5'd0, 5'd0);
      exp_q.push_back(32'd1);
      #4;
      exp = exp_q.pop_front(); checks++;
      if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL dfull_fill_%0d: got %0b want %0b", c, id_ready, exp[0]); end
    end
    new_cycle(); drive_id(1'b1, 5'd9, 5'd0, 5'd0);
    exp_q.push_back(32'd0);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL dfull_block: got %0b want %0b", id_ready, exp[0]); end
    new_cycle(); drive_id(1'b1, 5'd9, 5'd0, 5'd0); drive_wb(5'd9, 32'h0);
    exp_q.push_back(32'd1);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL dfull_wb_release: got %0b want %0b", id_ready, exp[0]); end
    new_cycle(); drive_id(1'b1, 5'd9, 5'd0, 5'd0);
    exp_q.push_back(32'd0);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL dfull_still_three: got %0b want %0b", id_ready, exp[0]); end
    for (int c = 1; c <= 3; c++) begin
      new_cycle(); drive_wb(5'd9, 32'(c)); drive_id(1'b0, 5'd0, 5'd9, 5'd0);
      exp_q.push_back((c == 3) ? 32'd1 : 32'd0);
      #4;
      exp = exp_q.pop_front(); checks++;
      if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL dfull_drain_%0d: got %0b want %0b", c, id_ready, exp[0]); end
    end
    new_cycle(); id_rs1 = 5'd9;
    exp_q.push_back(32'd1); exp_q.push_back(32'd3);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL dfull_idle: got %0b want %0b", idle, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL dfull_last_data: got %h want %h", rs1_data, exp); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 2; c++) begin
      new_cycle(); drive_id(1'b1, 5'd3, 5'd0, 5'd0);
      #4;
    end
    new_cycle(); flush = 1'b1; drive_id(1'b1, 5'd3, 5'd0, 5'd0); drive_wb(5'd10, 32'h77);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL flush_ready: got %0b want %0b", id_ready, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL flush_pending_before: got %0b want %0b", idle, exp[0]); end
    new_cycle(); drive_id(1'b0, 5'd0, 5'd3, 5'd10);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'h77);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL flush_idle: got %0b want %0b", idle, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL flush_unblocked: got %0b want %0b", id_ready, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin failures++; $display("FAIL flush_wb_commit: got %h want %h", rs2_data, exp); end
    new_cycle(); drive_wb(5'd3, 32'hA5); id_rs1 = 5'd3;
    exp_q.push_back(32'hA5);
    #4;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL flush_late_bypass: got %h want %h", rs1_data, exp); end
    new_cycle(); drive_id(1'b0, 5'd0, 5'd3, 5'd0);
    exp_q.push_back(32'hA5); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #4;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL flush_late_commit: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL flush_saturate_idle: got %0b want %0b", idle, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL flush_saturate_ready: got %0b want %0b", id_ready, exp[0]); end
  endtask

  task automatic test_mid_reset();
    new_cycle(); drive_id(1'b1, 5'd4, 5'd0, 5'd0);
    #4;
    new_cycle(); reset = 1'b1; drive_id(1'b0, 5'd0, 5'd4, 5'd0);
    exp_q.push_back(32'd0);
    #4;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, id_ready} !== exp) begin failures++; $display("FAIL midreset_ready: got %0b want %0b", id_ready, exp[0]); end
    new_cycle(); drive_id(1'b0, 5'd0, 5'd5, 5'd7);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    #4;
    exp = exp_q.pop_front(); checks++;
    if (rs1_data !== exp) begin failures++; $display("FAIL midreset_x5: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rs2_data !== exp) begin failures++; $display("FAIL midreset_x7: got %h want %h", rs2_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, idle} !== exp) begin failures++; $display("FAIL midreset_idle: got %0b want %0b", idle, exp[0]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    wb_valid = 1'b0; wb_R_wen = 1'b0; wb_rd = '0; wb_rd_value = '0;
    id_valid = 1'b0; id_R_wen = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    test_reset();
    test_write_bypass();
    test_x0();
    test_raw_stall();
    test_dest_saturation();
    test_flush();
    test_mid_reset();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
